tmds_serializer_multi: RTL and testbench

Parametrised, fabric-only N:1 parallel-to-serial converter for the HDMI TX path; it replaces per-lane vendor serializer primitives where a single fast clock is available. Accepts one word per channel through a valid/ready handshake and buffers words in a small FIFO. All channels shift out in lock-step. On starvation it inserts a programmable idle word and raises a sticky underrun flag.

---
 rtl/tmds_serializer_multi.sv | 69 ++++++
 tb/tb_tmds_serializer_multi.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_serializer_multi.sv
// tmds_serializer_multi: FIFO-buffered lock-step N:1 serializer (i_data/i_valid/o_ready in; o_serial, o_word_start, o_underrun, o_active out)
module tmds_serializer_multi #(
  parameter int CHANNELS = 3,
  parameter int WORD_W = 10,
  parameter int FIFO_DEPTH = 2,
  parameter bit LSB_FIRST = 1'b1,
  parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [CHANNELS*WORD_W-1:0] i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_clr_underrun,
  output logic [CHANNELS-1:0]        o_serial,
  output logic                       o_word_start,
  output logic                       o_underrun,
  output logic                       o_active
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORD_W);
  localparam int DW = CHANNELS * WORD_W;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [CW-1:0] bit_cnt;
  logic [WORD_W-2:0] sr [CHANNELS];
  logic [WORD_W-1:0] nw [CHANNELS];
  logic [DW-1:0] head;
  logic full, empty, load, push, pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_ready = !full;
  assign load = bit_cnt == CW'(WORD_W - 1);
  assign push = i_valid && !full;
  assign pop = load && !empty;
  assign head = mem[rd_ptr[AW-1:0]];
  always_comb begin
    nw = '{default: '0};
    for (int c = 0; c < CHANNELS; c++)
      for (int b = 0; b < WORD_W; b++)
        nw[c][b] = empty ? IDLE_WORD[LSB_FIRST ? b : WORD_W-1-b]
                         : head[c*WORD_W + (LSB_FIRST ? b : WORD_W-1-b)];
  end
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bit_cnt <= CW'(WORD_W - 1);
      sr <= '{default: '0};
      o_serial <= '0;
      o_word_start <= 1'b0;
      o_underrun <= 1'b0;
      o_active <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (pop) o_active <= 1'b1;
      bit_cnt <= load ? '0 : bit_cnt + CW'(1);
      o_word_start <= load;
      o_underrun <= (load && empty && o_active) || (o_underrun && !i_clr_underrun);
      for (int c = 0; c < CHANNELS; c++) begin
        o_serial[c] <= load ? nw[c][0] : sr[c][0];
        sr[c] <= load ? nw[c][WORD_W-1:1] : sr[c] >> 1;
      end
    end
  end
endmodule

// File: tb/tb_tmds_serializer_multi.sv
// tb_tmds_serializer_multi: randomized bench against a queue-based word-level model, LSB- and MSB-first instances
module tb_tmds_serializer_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic clr = 1'b0;
  logic [29:0] data = '0;
  logic [2:0] ser, ser_m;
  logic ws, ws_m, ready, ready_m, und, und_m, act, act_m;
  int checks = 0;
  int errors = 0;
  logic [9:0] idle_v = 10'b1101010100;
  tmds_serializer_multi dut (
    .i_clk(clk), .i_reset(rst), .i_data(data), .i_valid(valid), .o_ready(ready),
    .i_clr_underrun(clr), .o_serial(ser), .o_word_start(ws), .o_underrun(und), .o_active(act)
  );
  tmds_serializer_multi #(.LSB_FIRST(1'b0)) dut_m (
    .i_clk(clk), .i_reset(rst), .i_data(data), .i_valid(valid), .o_ready(ready_m),
    .i_clr_underrun(clr), .o_serial(ser_m), .o_word_start(ws_m), .o_underrun(und_m), .o_active(act_m)
  );
  always #5 clk = ~clk;
  logic [29:0] q[$];
  logic [9:0] cur [3] = '{default: '0};
  int phase = 9;
  bit started = 0;
  bit m_active = 0;
  bit m_under = 0;
  bit acc, set_u;
  logic [29:0] g;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      phase = 9;
      started = 0;
      m_active = 0;
      m_under = 0;
      for (int c = 0; c < 3; c++) cur[c] = '0;
    end else begin
      acc = valid && q.size() < 2;
      set_u = 0;
      started = 1;
      if (phase == 9) begin
        phase = 0;
        if (q.size() > 0) begin
          g = q.pop_front();
          m_active = 1;
        end else begin
          g = {3{idle_v}};
          set_u = m_active;
        end
        for (int c = 0; c < 3; c++) cur[c] = g[c*10 +: 10];
      end else phase++;
      m_under = set_u || (m_under && !clr);
      if (acc) q.push_back(data);
    end
  end
  function automatic logic [12:0] exp_vec();
    logic [2:0] s, m;
    logic w;
    for (int c = 0; c < 3; c++) begin
      s[c] = started ? cur[c][phase] : 1'b0;
      m[c] = started ? cur[c][9-phase] : 1'b0;
    end
    w = started && phase == 0;
    return {s, m, w, w, m_under, m_under, m_active, m_active, q.size() < 2};
  endfunction
  function automatic logic [12:0] act_vec();
    return {ser, ser_m, ws, ws_m, und, und_m, act, act_m, ready};
  endfunction
  task automatic test_reset();
    rst = 1;
    valid = 0;
    clr = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ser, ser_m, ws, ws_m, und, und_m, act, act_m} !== 10'b0 || ready !== 1'b1 || ready_m !== 1'b1) begin
      errors++;
      $display("FAIL reset_values got=%b ready=%b/%b want=0 ready=1", {ser, ser_m, ws, ws_m, und, und_m, act, act_m}, ready, ready_m);
    end
    rst = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_model cyc=%0d got=%b want=%b", k, act_vec(), exp_vec());
      end
      checks++;
      if (ser !== {3{idle_v[(k-1)%10]}} || ser_m !== {3{idle_v[9-(k-1)%10]}} || ws !== ((k-1)%10 == 0)) begin
        errors++;
        $display("FAIL idle_pattern cyc=%0d got ser=%b msb=%b ws=%b want bit=%b/%b ws=%b", k, ser, ser_m, ws,
                 idle_v[(k-1)%10], idle_v[9-(k-1)%10], (k-1)%10 == 0);
      end
    end
  endtask
  task automatic test_single();
    logic [9:0] s0 = '0, s1 = '1, s2 = ~10'h2AA;
    valid = 1;
    data = {10'h2AA, 10'h000, 10'h3FF};
    @(negedge clk);
    valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_model cyc=%0d got=%b want=%b", i, act_vec(), exp_vec());
      end
      if (started && cur[0] == 10'h3FF && cur[1] == 10'h000 && cur[2] == 10'h2AA) begin
        s0[phase] = ser[0];
        s1[phase] = ser[1];
        s2[phase] = ser[2];
      end
    end
    checks++;
    if (s0 !== 10'h3FF || s1 !== 10'h000 || s2 !== 10'h2AA) begin
      errors++;
      $display("FAIL single_lanes got=%h,%h,%h want=3ff,000,2aa", s0, s1, s2);
    end
    checks++;
    if (act !== 1'b1 || und !== 1'b1) begin
      errors++;
      $display("FAIL single_flags got act=%b und=%b want 1 1", act, und);
    end
  endtask
  task automatic test_throughput();
    int n = 0;
    valid = 1;
    clr = 1;
    data = 30'($urandom);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL thru_model cyc=%0d got=%b want=%b", i, act_vec(), exp_vec());
      end
      if (ready) n++;
      clr = i < 12;
      data = 30'($urandom);
    end
    valid = 0;
    clr = 0;
    checks++;
    if (n < 20 || n > 22 || und !== 1'b0) begin
      errors++;
      $display("FAIL thru_rate got accepts=%0d und=%b want 20..22 und=0", n, und);
    end
  endtask
  task automatic test_underrun_clr();
    int t = 0;
    while (!m_under && t < 50) begin
      @(negedge clk);
      t++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL urun_model cyc=%0d got=%b want=%b", t, act_vec(), exp_vec());
      end
    end
    if (phase == 9) @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    checks++;
    if (und !== 1'b0 || t >= 50) begin
      errors++;
      $display("FAIL urun_clear got und=%b wait=%0d want und=0", und, t);
    end
    t = 0;
    while (phase != 9 && t < 12) begin
      @(negedge clk);
      t++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL urun_model2 cyc=%0d got=%b want=%b", t, act_vec(), exp_vec());
      end
    end
    clr = 1;
    @(negedge clk);
    clr = 0;
    checks++;
    if (und !== 1'b1) begin
      errors++;
      $display("FAIL urun_setwins got und=%b want 1", und);
    end
  endtask
  task automatic test_msb();
    logic [9:0] p1 = 10'b1000000001, p2 = 10'b1100000000;
    logic [9:0] m1 = ~p1, m2 = ~p2;
    valid = 1;
    data = {20'($urandom), p1};
    @(negedge clk);
    data = {20'($urandom), p2};
    @(negedge clk);
    valid = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL msb_model cyc=%0d got=%b want=%b", i, act_vec(), exp_vec());
      end
      if (started && cur[0] == p1) m1[9-phase] = ser_m[0];
      if (started && cur[0] == p2) m2[9-phase] = ser_m[0];
    end
    checks++;
    if (m1 !== p1 || m2 !== p2) begin
      errors++;
      $display("FAIL msb_order got=%b,%b want=%b,%b", m1, m2, p1, p2);
    end
  endtask
  task automatic test_reset_mid();
    logic [29:0] w1 = 30'($urandom), w2 = 30'($urandom);
    int t = 0;
    w1[0] = ~idle_v[0];
    valid = 1;
    data = w1;
    @(negedge clk);
    data = w2;
    @(negedge clk);
    valid = 0;
    while (!(started && phase == 4 && q.size() == 1 && {cur[2], cur[1], cur[0]} == w1) && t < 40) begin
      @(negedge clk);
      t++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_model cyc=%0d got=%b want=%b", t, act_vec(), exp_vec());
      end
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({ser, ser_m, ws, ws_m, und, und_m, act, act_m} !== 10'b0 || ready !== 1'b1 || t >= 40) begin
      errors++;
      $display("FAIL mid_async got=%b ready=%b wait=%0d want=0 ready=1", {ser, ser_m, ws, ws_m, und, und_m, act, act_m}, ready, t);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_after cyc=%0d got=%b want=%b", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (act !== 1'b0 || ser !== {3{idle_v[4]}}) begin
      errors++;
      $display("FAIL mid_discard got act=%b ser=%b want act=0 ser=%b", act, ser, {3{idle_v[4]}});
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom % 3) != 0;
      data = 30'($urandom);
      clr = ($urandom % 16) == 0;
      @(negedge clk);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_model cyc=%0d got=%b want=%b", i, act_vec(), exp_vec());
      end
    end
    valid = 0;
    clr = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_throughput();
    test_underrun_clr();
    test_msb();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
